mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Memory-side sequencer answering the CPU's address register: takes the latched
//   16-bit address plus a read/write command and runs one access on the external
//   asynchronous SRAM port.
// - Read data is returned to the data path, and done/err tell the control unit
//   when the cycle is finished.
// - Sits between the address register / control unit and the RAM pins.
//   Handles one access at a time; there is no queue.
// PARAMETERS
// - ADDR_W       16   address width; must match the address register output
// - DATA_W       16   memory data width
// - WAIT_CYCLES   2   minimum ACCESS cycles before mem_ready is sampled (0..15)
// - TIMEOUT      15   extra ACCESS cycles allowed for mem_ready before abort (1..255)
// PORTS
// - clk         in   1       system clock; all logic on rising edge
// - reset       in   1       synchronous reset, active-high
// - addr_in     in   ADDR_W  access address, from address register q
// - wr_data     in   DATA_W  write data, sampled with the command
// - rd_en       in   1       read command, sampled in IDLE only
// - wr_en       in   1       write command, sampled in IDLE only
// - busy        out  1       high in every state except IDLE
// - done        out  1       one-cycle pulse when the access ends (success or timeout)
// - err         out  1       one-cycle pulse: rd_en&wr_en both high, or timeout
// - rd_data     out  DATA_W  last successful read data; holds its value otherwise
// - mem_addr    out  ADDR_W  RAM address; stable from SETUP through HOLD
// - mem_wdata   out  DATA_W  RAM write data; stable from SETUP through HOLD
// - mem_rdata   in   DATA_W  RAM read data
// - mem_ready   in   1       RAM ready for the current access
// - mem_ce      out  1       chip enable
// - mem_we      out  1       write strobe
// - mem_oe      out  1       output enable (reads)
// BEHAVIOUR
// - Reset values, and the state forced by reset mid-access:
//   - state=IDLE; busy/done/err/mem_ce/mem_we/mem_oe=0; rd_data/mem_addr/mem_wdata=0.
//   - A reset during an access aborts it. All strobes are low from the next cycle.
//     rd_data is not updated.
// - All outputs are registered.
// - FSM: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
// - IDLE:
//   - rd_en xor wr_en: latch addr_in, wr_data and direction; go to SETUP.
//   - rd_en & wr_en: err pulse, no access, stay in IDLE.
// - SETUP (1 cycle):
//   - mem_ce=1, mem_we=0, mem_oe=0, so the address is set up before the strobe.
//   - Load wait_cnt=WAIT_CYCLES, clear to_cnt.
// - ACCESS:
//   - mem_ce=1; mem_we=write; mem_oe=read.
//   - While wait_cnt!=0: decrement wait_cnt.
//   - wait_cnt==0 & mem_ready: capture mem_rdata into rd_data on a read; go to HOLD.
//   - wait_cnt==0 & !mem_ready: increment to_cnt.
//   - to_cnt==TIMEOUT: go to HOLD with a timeout flag; rd_data is not updated.
// - HOLD (1 cycle):
//   - mem_ce=1, mem_we=0, mem_oe=0 (address hold).
//   - done=1; err=1 if the timeout flag is set.
//   - Go to IDLE.
// - Latency, with mem_ready always high: WAIT_CYCLES+3 cycles from the command edge
//   to done; 5 cycles at the default.
// - rd_en/wr_en while busy: ignored, never queued. Control re-issues after done.
// - Back-to-back: a command present in the cycle after done starts a new access.
// - mem_we and mem_oe are never high in the same cycle.
// STRUCTURE
// - mem_pkg holds: FSM state typedef (2-bit), default WAIT_CYCLES/TIMEOUT,
//   direction constants.
// - One sub-module, mem_wait_counter: the loadable down-counter (wait_cnt) plus the
//   timeout up-counter; outputs wait_zero and timed_out.
// TESTING
// - Read: addr_in=16'h0040, rd_en 1 cycle, mem_rdata=16'hBEEF, ready=1
//   -> done 5 cycles later, rd_data=16'hBEEF, err=0.
// - Write: addr_in=16'h1234, wr_data=16'h00A5, wr_en
//   -> mem_we high WAIT_CYCLES+1 cycles, mem_addr/mem_wdata stable SETUP..HOLD.
// - Slow RAM: mem_ready high 3 cycles late -> done at cycle 8, rd_data correct.
// - Timeout: mem_ready tied 0 -> done & err together; rd_data keeps 16'hBEEF.
// - rd_en & wr_en in IDLE -> err 1 cycle, busy stays 0, no strobes.
// - reset during ACCESS -> next cycle state=IDLE and all strobes 0;
//   a read then works normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the SRAM access sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StHold
  } mem_state_e;

  localparam int unsigned DefaultWaitCycles = 2;
  localparam int unsigned DefaultTimeout    = 15;

  localparam logic DirRead  = 1'b0;
  localparam logic DirWrite = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// Access-phase timing: a loadable wait down-counter followed by a ready-timeout up-counter.
module mem_wait_counter import mem_pkg::*; #(
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles,
  parameter int unsigned TIMEOUT     = DefaultTimeout
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic step,
  output logic wait_zero,
  output logic timed_out
);

  logic [3:0] wait_cnt_q;
  logic [7:0] to_cnt_q;

  assign wait_zero = (wait_cnt_q == 4'd0);
  assign timed_out = (to_cnt_q == 8'(TIMEOUT));

  // The timeout count only advances once the minimum wait has elapsed.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
      to_cnt_q   <= 8'd0;
    end else if (load) begin
      wait_cnt_q <= 4'(WAIT_CYCLES);
      to_cnt_q   <= 8'd0;
    end else if (step) begin
      if (!wait_zero) begin
        wait_cnt_q <= wait_cnt_q - 4'd1;
      end else if (!timed_out) begin
        to_cnt_q <= to_cnt_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-access sequencer driving an asynchronous SRAM port; all outputs are registered.
module mem_access_unit import mem_pkg::*; #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_CYCLES = DefaultWaitCycles,
  parameter int unsigned TIMEOUT     = DefaultTimeout
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_oe
);

  mem_state_e state_q, state_d;
  logic       dir_q;
  logic       wait_zero, timed_out;
  logic       ready_hit, abort, cmd_start, cmd_clash;

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .TIMEOUT    (TIMEOUT)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (state_q == StSetup),
    .step     (state_q == StAccess),
    .wait_zero(wait_zero),
    .timed_out(timed_out)
  );

  assign cmd_start = (state_q == StIdle) && (rd_en ^ wr_en);
  assign cmd_clash = (state_q == StIdle) && rd_en && wr_en;

  always_comb begin
    state_d   = state_q;
    ready_hit = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_start) state_d = StSetup;
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // A ready on the final allowed cycle still completes the access.
        if (wait_zero) begin
          if (mem_ready) begin
            state_d   = StHold;
            ready_hit = 1'b1;
          end else if (timed_out) begin
            state_d = StHold;
            abort   = 1'b1;
          end
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      dir_q     <= DirRead;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_start) begin
        dir_q     <= wr_en ? DirWrite : DirRead;
        mem_addr  <= addr_in;
        mem_wdata <= wr_data;
      end
      if (ready_hit && (dir_q == DirRead)) begin
        rd_data <= mem_rdata;
      end
      busy   <= (state_d != StIdle);
      done   <= (state_d == StHold);
      err    <= abort || cmd_clash;
      mem_ce <= (state_d != StIdle);
      mem_we <= (state_d == StAccess) && (dir_q == DirWrite);
      mem_oe <= (state_d == StAccess) && (dir_q == DirRead);
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a cycle-count reference model and SRAM model.
module tb_mem_access_unit;

  localparam int unsigned W  = 2;
  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr_in, wr_data, mem_rdata;
  logic        rd_en, wr_en, mem_ready;
  logic        busy, done, err, mem_ce, mem_we, mem_oe;
  logic [15:0] rd_data, mem_addr, mem_wdata;

  int          vectors;
  int          miscompares;
  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];
  logic [15:0] exp_rd;

  mem_access_unit #(
    .ADDR_W     (16),
    .DATA_W     (16),
    .WAIT_CYCLES(W),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr_in  (addr_in),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .rd_data  (rd_data),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe)
  );

  always #5 clk = ~clk;

  // External SRAM: combinational read, write on a strobed ready edge.
  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_ce && mem_we && mem_ready) ram[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] status();
    return {busy, done, err, mem_ce, mem_we, mem_oe};
  endfunction

  // Ready rises lat cycles after the minimum wait; lat > TO means the RAM never answers.
  task automatic run_access(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                            input int lat, input bit noise);
    bit          tmo;
    int          dcyc;
    bit          in_acc;
    logic [5:0]  exp_st;
    tmo  = (lat > int'(TO));
    dcyc = tmo ? int'(W + 3 + TO) : int'(W + 3) + lat;
    rd_en   = !is_wr;
    wr_en   = is_wr;
    addr_in = a;
    wr_data = d;
    @(posedge clk);
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      rd_en   = (noise && c < dcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_en   = (noise && c < dcyc) ? 1'($urandom_range(0, 1)) : 1'b0;
      addr_in = 16'($urandom);
      wr_data = 16'($urandom);
      in_acc  = (c >= 2) && (c < dcyc);
      exp_st  = {1'b1, c == dcyc, tmo && (c == dcyc), 1'b1, is_wr && in_acc, !is_wr && in_acc};
      check_eq("status", 32'(status()), 32'(exp_st));
      check_eq("mem_addr", 32'(mem_addr), 32'(a));
      if (is_wr) check_eq("mem_wdata", 32'(mem_wdata), 32'(d));
      mem_ready = (c < dcyc) && (c >= int'(W + 2) + lat);
    end
    if (!tmo) begin
      if (is_wr) ref_mem[a[7:0]] = d;
      else       exp_rd = ref_mem[a[7:0]];
    end
    @(negedge clk);
    check_eq("idle_after", 32'(status()), 32'd0);
    check_eq("rd_data", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic run_clash();
    rd_en   = 1'b1;
    wr_en   = 1'b1;
    addr_in = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    check_eq("clash_err", 32'(status()), 32'b001000);
    @(negedge clk);
    check_eq("clash_clear", 32'(status()), 32'd0);
    check_eq("clash_rd", 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic run_mid_reset(input logic [15:0] a);
    rd_en   = 1'b1;
    wr_en   = 1'b0;
    addr_in = a;
    @(posedge clk);
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_reset_access", 32'(status()), 32'b100101);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_reset_status", 32'(status()), 32'd0);
    check_eq("mid_reset_addr", 32'(mem_addr), 32'd0);
    exp_rd = 16'h0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    addr_in     = '0;
    wr_data     = '0;
    mem_ready   = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[8'h40]     = 16'hBEEF;
    ref_mem[8'h40] = 16'hBEEF;
    exp_rd         = 16'h0;

    repeat (3) @(negedge clk);
    check_eq("reset_status", 32'(status()), 32'd0);
    check_eq("reset_rd_data", 32'(rd_data), 32'd0);
    check_eq("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b0;

    run_access(1'b0, 16'h0040, 16'h0000, 0, 1'b0);
    check_eq("read_beef", 32'(rd_data), 32'h0000BEEF);
    run_access(1'b1, 16'h1234, 16'h00A5, 0, 1'b0);
    run_access(1'b0, 16'h0077, 16'h0000, 99, 1'b0);
    check_eq("timeout_keeps", 32'(rd_data), 32'h0000BEEF);
    run_access(1'b0, 16'h1234, 16'h0000, 3, 1'b0);
    check_eq("slow_read", 32'(rd_data), 32'h000000A5);
    run_access(1'b0, 16'h0040, 16'h0000, int'(TO), 1'b1);
    run_clash();
    run_mid_reset(16'h0040);
    run_access(1'b0, 16'h0040, 16'h0000, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        run_clash();
      end else begin
        run_access(1'($urandom_range(0, 1)),
                   {8'($urandom), 4'h0, 4'($urandom_range(0, 15))},
                   16'($urandom),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 20))
                                               : int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
